// File: rtl/cookie_game_if.sv
// cookie_game_if: game control bundle; master drives en/start/rnd_number/buttons, slave returns cookie/score/misses/game_over/pulses
interface cookie_game_if;
  logic en;
  logic start;
  logic [15:0] rnd_number;
  logic [7:0] buttons;
  logic [7:0] cookie;
  logic [7:0] score;
  logic [1:0] misses;
  logic game_over;
  logic hit_pulse;
  logic miss_pulse;
  modport master(output en, start, rnd_number, buttons, input cookie, score, misses, game_over, hit_pulse, miss_pulse);
  modport slave(input en, start, rnd_number, buttons, output cookie, score, misses, game_over, hit_pulse, miss_pulse);
endinterface

// File: rtl/cookie_game_ctrl.sv
// cookie_game_ctrl: whack-a-cookie game FSM; ports clk, rst (sync, active-high) and cookie_game_if.slave bus (en, start, rnd_number, buttons in; cookie, score, misses, game_over, hit_pulse, miss_pulse out)
module cookie_game_ctrl #(
  parameter int GAP_CYCLES = 1000,
  parameter int SHOW_CYCLES = 50000,
  parameter int MAX_MISSES = 3
) (
  input logic clk,
  input logic rst,
  cookie_game_if.slave bus
);
  localparam int TW = $clog2((GAP_CYCLES > SHOW_CYCLES ? GAP_CYCLES : SHOW_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, GAP, SHOW, OVER} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [7:0] buttons_q, press, cookie, score;
  logic [2:0] prev, pos;
  logic [1:0] misses, misses_n;
  logic game_over, hit_pulse, miss_pulse, hit, miss, last_miss;
  logic unused;
  assign unused = ^bus.rnd_number[15:3];
  assign press = bus.buttons & ~buttons_q;
  assign pos = bus.rnd_number[2:0] + 3'(bus.rnd_number[2:0] == prev);
  assign hit = press == cookie;
  assign miss = |press | (timer == '0);
  assign misses_n = misses + 2'd1;
  assign last_miss = misses_n == 2'(MAX_MISSES);
  assign bus.cookie = cookie;
  assign bus.score = score;
  assign bus.misses = misses;
  assign bus.game_over = game_over;
  assign bus.hit_pulse = hit_pulse;
  assign bus.miss_pulse = miss_pulse;
  always_ff @(posedge clk) begin
    buttons_q <= rst ? '0 : bus.buttons;
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      cookie <= '0;
      score <= '0;
      misses <= '0;
      game_over <= 1'b0;
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      prev <= '0;
    end else begin
      hit_pulse <= 1'b0;
      miss_pulse <= 1'b0;
      if (bus.en) begin
        case (state)
          IDLE, OVER: if (bus.start) begin
            state <= GAP;
            timer <= TW'(GAP_CYCLES - 1);
            score <= '0;
            misses <= '0;
            game_over <= 1'b0;
          end
          GAP: if (timer == '0) begin
            state <= SHOW;
            cookie <= 8'd1 << pos;
            prev <= pos;
            timer <= TW'(SHOW_CYCLES - 1);
          end else timer <= timer - 1'b1;
          SHOW: if (hit) begin
            score <= score + 8'(score != 8'hff);
            hit_pulse <= 1'b1;
            cookie <= '0;
            state <= GAP;
            timer <= TW'(GAP_CYCLES - 1);
          end else if (miss) begin
            misses <= misses_n;
            miss_pulse <= 1'b1;
            cookie <= '0;
            state <= last_miss ? OVER : GAP;
            game_over <= last_miss;
            timer <= TW'(GAP_CYCLES - 1);
          end else timer <= timer - 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cookie_game_ctrl.sv
// tb_cookie_game_ctrl: directed and randomized checks of cookie_game_ctrl against a phase-level game model
module tb_cookie_game_ctrl;
  localparam int GAP = 2;
  localparam int SHOW = 4;
  localparam int MAXM = 3;
  localparam int M_IDLE = 0, M_GAP = 1, M_SHOW = 2, M_OVER = 3;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int m_mode, m_left, m_pos, m_prev, m_score, m_miss;
  bit m_hp, m_mp;
  logic [7:0] m_bq;
  always #5 clk = ~clk;
  cookie_game_if b();
  cookie_game_ctrl #(.GAP_CYCLES(GAP), .SHOW_CYCLES(SHOW), .MAX_MISSES(MAXM)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  function automatic logic [20:0] exp_vec();
    logic [7:0] c;
    c = (m_mode == M_SHOW) ? 8'd1 << m_pos : 8'd0;
    return {c, 8'(m_score), 2'(m_miss), m_mode == M_OVER, m_hp, m_mp};
  endfunction
  task automatic tick();
    logic [7:0] press;
    int r;
    @(posedge clk);
    press = b.buttons & ~m_bq;
    m_bq = rst ? 8'd0 : b.buttons;
    if (rst) begin
      m_mode = M_IDLE; m_left = 0; m_prev = 0; m_pos = 0; m_score = 0; m_miss = 0; m_hp = 0; m_mp = 0;
    end else begin
      m_hp = 0; m_mp = 0;
      if (b.en) begin
        if ((m_mode == M_IDLE || m_mode == M_OVER) && b.start) begin
          m_mode = M_GAP; m_left = GAP; m_score = 0; m_miss = 0;
        end else if (m_mode == M_GAP) begin
          if (m_left == 1) begin
            r = int'(b.rnd_number[2:0]);
            m_pos = (r == m_prev) ? (r + 1) % 8 : r;
            m_prev = m_pos; m_mode = M_SHOW; m_left = SHOW;
          end else m_left--;
        end else if (m_mode == M_SHOW) begin
          if (press == (8'd1 << m_pos)) begin
            m_score = (m_score == 255) ? 255 : m_score + 1;
            m_hp = 1; m_mode = M_GAP; m_left = GAP;
          end else if (press != 0 || m_left == 1) begin
            m_miss++; m_mp = 1; m_mode = (m_miss == MAXM) ? M_OVER : M_GAP; m_left = GAP;
          end else m_left--;
        end
      end
    end
    #1;
  endtask
  task automatic wait_show();
    int n = 0;
    while (m_mode != M_SHOW && n < 20) begin tick(); n++; end
    checks++;
    if (m_mode != M_SHOW || b.cookie !== (8'd1 << m_pos)) begin failures++; $display("FAIL wait_show cookie=%h required=%h", b.cookie, 8'd1 << m_pos); end
  endtask
  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++; if ({b.cookie, b.score, b.misses, b.game_over, b.hit_pulse, b.miss_pulse} !== 21'd0) begin failures++; $display("FAIL reset_outputs got=%h required=0", {b.cookie, b.score, b.misses, b.game_over, b.hit_pulse, b.miss_pulse}); end
    rst = 0;
  endtask
  task automatic test_hit();
    b.rnd_number = 16'h0005; b.start = 1; tick(); b.start = 0;
    tick();
    checks++; if (b.cookie !== 8'h00) begin failures++; $display("FAIL gap_cookie got=%h required=00", b.cookie); end
    tick();
    checks++; if (b.cookie !== 8'h20) begin failures++; $display("FAIL first_cookie got=%h required=20", b.cookie); end
    b.buttons = 8'h20; tick(); b.buttons = 0;
    checks++; if ({b.hit_pulse, b.miss_pulse, b.score, b.cookie} !== {2'b10, 8'd1, 8'h00}) begin failures++; $display("FAIL hit got=%b/%b/%0d/%h required=1/0/1/00", b.hit_pulse, b.miss_pulse, b.score, b.cookie); end
  endtask
  task automatic test_timeout();
    tick(); tick();
    checks++; if (b.cookie !== 8'h40) begin failures++; $display("FAIL repeat_cookie got=%h required=40", b.cookie); end
    repeat (3) tick();
    checks++; if (b.cookie !== 8'h40 || b.miss_pulse !== 1'b0) begin failures++; $display("FAIL show_hold cookie=%h miss=%b required=40/0", b.cookie, b.miss_pulse); end
    tick();
    checks++; if ({b.miss_pulse, b.hit_pulse, b.misses, b.cookie} !== {2'b10, 2'd1, 8'h00}) begin failures++; $display("FAIL timeout_miss got=%b/%b/%0d/%h required=1/0/1/00", b.miss_pulse, b.hit_pulse, b.misses, b.cookie); end
  endtask
  task automatic test_wrong_bit();
    tick(); tick();
    checks++; if (b.cookie !== 8'h20) begin failures++; $display("FAIL wrong_cookie got=%h required=20", b.cookie); end
    b.buttons = 8'h21; tick(); b.buttons = 0;
    checks++; if ({b.miss_pulse, b.hit_pulse, b.misses, b.score} !== {2'b10, 2'd2, 8'd1}) begin failures++; $display("FAIL wrong_bit got=%b/%b/%0d/%0d required=1/0/2/1", b.miss_pulse, b.hit_pulse, b.misses, b.score); end
  endtask
  task automatic test_wrap();
    b.rnd_number = 16'hfff7; tick(); tick();
    checks++; if (b.cookie !== 8'h80) begin failures++; $display("FAIL cookie7 got=%h required=80", b.cookie); end
    b.buttons = 8'h80; tick(); b.buttons = 0; tick(); tick();
    checks++; if (b.cookie !== 8'h01) begin failures++; $display("FAIL wrap_cookie got=%h required=01", b.cookie); end
    b.buttons = 8'h01; tick(); b.buttons = 0;
    checks++; if (b.score !== 8'd3 || b.hit_pulse !== 1'b1) begin failures++; $display("FAIL wrap_hit score=%0d hit=%b required=3/1", b.score, b.hit_pulse); end
  endtask
  task automatic test_game_over();
    tick(); tick(); repeat (4) tick();
    checks++; if ({b.game_over, b.miss_pulse, b.misses, b.cookie} !== {2'b11, 2'd3, 8'h00}) begin failures++; $display("FAIL game_over got=%b/%b/%0d/%h required=1/1/3/00", b.game_over, b.miss_pulse, b.misses, b.cookie); end
    for (int i = 0; i < 4; i++) begin
      b.buttons = (i % 2) ? 8'h00 : 8'hff; tick();
      checks++; if ({b.game_over, b.hit_pulse, b.miss_pulse, b.score, b.misses, b.cookie} !== {3'b100, 8'd3, 2'd3, 8'h00}) begin failures++; $display("FAIL over_hold go=%b hp=%b mp=%b score=%0d misses=%0d cookie=%h required=1/0/0/3/3/00", b.game_over, b.hit_pulse, b.miss_pulse, b.score, b.misses, b.cookie); end
    end
    b.buttons = 0; b.start = 1; tick(); b.start = 0;
    checks++; if ({b.game_over, b.score, b.misses, b.cookie} !== 19'd0) begin failures++; $display("FAIL restart go=%b score=%0d misses=%0d cookie=%h required=0/0/0/00", b.game_over, b.score, b.misses, b.cookie); end
  endtask
  task automatic test_enable();
    logic [7:0] lit;
    wait_show();
    lit = 8'd1 << m_pos;
    b.en = 0;
    for (int i = 0; i < 6; i++) begin
      b.buttons = (i == 2) ? lit : 8'h00; tick();
      checks++; if ({b.cookie, b.hit_pulse, b.miss_pulse} !== {lit, 2'b00}) begin failures++; $display("FAIL en_freeze cookie=%h hp=%b mp=%b required=%h/0/0", b.cookie, b.hit_pulse, b.miss_pulse, lit); end
    end
    b.buttons = lit; tick(); b.buttons = lit; b.en = 1; tick();
    checks++; if ({b.cookie, b.hit_pulse, b.miss_pulse} !== {lit, 2'b00}) begin failures++; $display("FAIL en_lost_press cookie=%h hp=%b mp=%b required=%h/0/0", b.cookie, b.hit_pulse, b.miss_pulse, lit); end
    b.buttons = 0;
  endtask
  task automatic test_saturate();
    rst = 1; tick(); rst = 0;
    b.start = 1; tick(); b.start = 0;
    for (int i = 0; i < 256; i++) begin
      b.rnd_number = 16'($urandom);
      wait_show();
      b.buttons = 8'd1 << m_pos; tick(); b.buttons = 0;
    end
    checks++; if (b.score !== 8'd255 || b.hit_pulse !== 1'b1 || b.misses !== 2'd0) begin failures++; $display("FAIL saturate score=%0d hit=%b misses=%0d required=255/1/0", b.score, b.hit_pulse, b.misses); end
    wait_show();
    rst = 1; tick(); rst = 0;
    checks++; if ({b.cookie, b.score, b.misses, b.game_over, b.hit_pulse, b.miss_pulse} !== 21'd0) begin failures++; $display("FAIL rst_mid_show got=%h required=0", {b.cookie, b.score, b.misses, b.game_over, b.hit_pulse, b.miss_pulse}); end
  endtask
  task automatic test_random();
    int r;
    logic [20:0] got, exp;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      b.en = ($urandom_range(0, 9) != 0);
      b.start = ($urandom_range(0, 7) == 0);
      b.rnd_number = 16'($urandom);
      r = $urandom_range(0, 9);
      b.buttons = (r < 6) ? 8'h00 : (r < 8) ? ((m_mode == M_SHOW) ? 8'd1 << m_pos : 8'd1 << $urandom_range(0, 7)) : 8'($urandom);
      tick();
      got = {b.cookie, b.score, b.misses, b.game_over, b.hit_pulse, b.miss_pulse};
      exp = exp_vec();
      checks++; if (got !== exp) begin failures++; $display("FAIL random cycle=%0d got=%h required=%h", i, got, exp); end
    end
    rst = 0; b.en = 1; b.start = 0; b.buttons = 0;
  endtask
  initial begin
    rst = 1; b.en = 1; b.start = 0; b.buttons = 0; b.rnd_number = 0;
    m_bq = 0; m_mode = M_IDLE; m_left = 0; m_pos = 0; m_prev = 0; m_score = 0; m_miss = 0; m_hp = 0; m_mp = 0;
    test_reset();
    test_hit();
    test_timeout();
    test_wrong_bit();
    test_wrap();
    test_game_over();
    test_enable();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cookie_game_ctrl.md
COOKIE_GAME_CTRL -- requirements
Module: cookie_game_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, default 1000: blank cycles between cookies (min 1).
REQ-002 Parameter SHOW_CYCLES, default 50000: cycles a cookie stays lit (min 1).
REQ-003 Parameter MAX_MISSES, default 3: misses ending a game (1..3).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  design enable; low freezes state, timer, score, misses.
REQ-007 start  in  1  level; begins a game from IDLE or OVER.
REQ-008 rnd_number  in  16  free-running random word from the LFSR stage; only bits [2:0] used.
REQ-009 buttons  in  8  player switches, bit i = cookie slot i.
REQ-010 cookie  out  8  one-hot lit cookie slot, 0 when none lit.
REQ-011 score  out  8  hits this game, saturating.
REQ-012 misses  out  2  misses this game.
REQ-013 game_over  out  1  high while in OVER.
REQ-014 hit_pulse  out  1  one-cycle strobe per hit.
REQ-015 miss_pulse  out  1  one-cycle strobe per miss.

Function
REQ-016 States IDLE, GAP, SHOW, OVER; one cycle per transition; all outputs registered.
REQ-017 Edge detect: buttons_q <= buttons every cycle regardless of en; press = buttons & ~buttons_q.
REQ-018 IDLE/OVER, en=1, start=1 -> GAP; score=0, misses=0, timer=GAP_CYCLES-1, game_over=0.
REQ-019 GAP: cookie=0; timer decrements; timer==0 -> SHOW next cycle.
REQ-020 GAP->SHOW: pos=rnd_number[2:0]; if pos equals previous pos, pos=(pos+1) mod 8 (7 wraps to 0); cookie=1<<pos; timer=SHOW_CYCLES-1.
REQ-021 Previous pos resets to 0; first cookie of game obeys same repeat rule.
REQ-022 SHOW hit: press has cookie bit set and no other press bit -> score+1 (255 holds at 255), hit_pulse=1 next cycle, -> GAP, cookie=0, timer=GAP_CYCLES-1.
REQ-023 SHOW miss: any press bit outside cookie (even with correct bit) OR timer==0 with no press -> miss.
REQ-024 Correct-only press in same cycle as timer==0 counts as hit.
REQ-025 Miss: misses+1, miss_pulse=1 next cycle, cookie=0; new misses==MAX_MISSES -> OVER, else GAP with timer=GAP_CYCLES-1.
REQ-026 Presses in IDLE, GAP, OVER ignored; start ignored in GAP and SHOW.
REQ-027 OVER: game_over=1, cookie=0, score and misses held until next start.
REQ-028 en=0: state, timer, cookie, score, misses held; hit_pulse=miss_pulse=0; presses during en=0 lost (edge register still samples).
REQ-029 Pulses never both high; each high at most one cycle per event.

Reset
REQ-030 rst=1 at clock edge, any state incl. mid-SHOW: state=IDLE, cookie=0, score=0, misses=0, game_over=0, pulses=0, timer=0, prev pos=0, buttons_q=0.
REQ-031 rst has priority over en and start.

Verification (GAP_CYCLES=2, SHOW_CYCLES=4, MAX_MISSES=3, en=1)
REQ-032 rst, start 1 cycle, rnd_number=16'h0005 -> GAP 2 cycles then cookie=8'h20; press bit5 -> next cycle hit_pulse=1, score=1, cookie=0.
REQ-033 Cookie lit, no press 4 cycles -> miss_pulse=1, misses=1, cookie=0, then GAP.
REQ-034 Cookie=8'h20, buttons 0->8'h21 -> miss (wrong bit wins), score unchanged.
REQ-035 Prev pos 7, rnd_number[2:0]=7 -> cookie=8'h01.
REQ-036 Three misses -> game_over=1, cookie=0; presses ignored; start -> score=0, misses=0, game_over=0.
REQ-037 score=255 then hit -> score stays 255, hit_pulse=1; rst mid-SHOW -> all outputs 0 next cycle.
